// File: rtl/burst_mem_pkg.sv
// Shared types and defaults for the burst memory block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_mem_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_BURST_W = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR      = 2'd1;
    localparam logic [1:0] ST_RD      = 2'd2;
    localparam logic [1:0] ST_RD_TAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        WR      = ST_WR,
        RD      = ST_RD,
        RD_TAIL = ST_RD_TAIL
    } state_t;

endpackage

// File: rtl/burst_memory_inout_sp_ram_core.sv
// Single-port storage array: synchronous write, registered read.
// Latency: read data valid 1 cycle after re.
// Backpressure: none; caller gates we/re.
module sp_ram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents and the read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_memory_inout.sv
// Burst engine over a single-port RAM with a shared tri-state data bus.
// Latency: write beats land the cycle they are presented; read data 1 cycle after issue.
// Backpressure: cs low freezes an active WR/RD burst; start ignored while busy.
module burst_memory_inout
    import burst_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic               start,
    input  logic               write_en,
    input  logic               read_en,
    input  logic [ADDR_W-1:0]  address_in,
    input  logic [BURST_W-1:0] burst_len,
    inout  wire  [DATA_W-1:0]  data_io,
    output logic               busy,
    output logic               rd_valid,
    output logic               done
);

    localparam int DEPTH = 2**ADDR_W;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_ptr, addr_nxt;
    logic [BURST_W-1:0] beat_cnt, beat_nxt;
    logic               mem_we;
    logic               mem_re;
    logic [DATA_W-1:0]  rdata;

    sp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_ptr),
        .wdata (data_io),
        .rdata (rdata)
    );

    // State, pointer and counter registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_ptr <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            addr_ptr <= addr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // A read issued this cycle shows up on the bus next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= mem_re;
        end
    end

    // Next-state, beat stepping and done; a paused beat (cs low) changes nothing.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_ptr;
        beat_nxt  = beat_cnt;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && cs) begin
                    addr_nxt = address_in;
                    beat_nxt = burst_len;
                    // write takes priority when both command types are set
                    if (write_en) begin
                        state_nxt = WR;
                    end else if (read_en) begin
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                if (cs) begin
                    mem_we   = 1'b1;
                    addr_nxt = addr_ptr + 1'b1;
                    beat_nxt = beat_cnt - 1'b1;
                    if (beat_cnt == '0) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            RD: begin
                if (cs) begin
                    mem_re   = 1'b1;
                    addr_nxt = addr_ptr + 1'b1;
                    beat_nxt = beat_cnt - 1'b1;
                    if (beat_cnt == '0) begin
                        state_nxt = RD_TAIL;
                    end
                end
            end
            RD_TAIL: begin
                // last word is on the bus now; cs has no say here
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign data_io = rd_valid ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_burst_memory_inout.sv
module tb_burst_memory_inout;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       start = 1'b0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [3:0] address_in = 4'd0;
    logic [2:0] burst_len = 3'd0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_drv = 8'd0;
    wire  [7:0] data_io;
    logic       busy;
    logic       rd_valid;
    logic       done;

    int checks = 0;
    int errors = 0;

    assign data_io = tb_oe ? tb_drv : 8'hzz;

    burst_memory_inout #(
        .DATA_W  (8),
        .ADDR_W  (4),
        .BURST_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .start      (start),
        .write_en   (write_en),
        .read_en    (read_en),
        .address_in (address_in),
        .burst_len  (burst_len),
        .data_io    (data_io),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command cycle; returns in the first cycle after the start edge.
    task automatic cmd(input logic w, input logic r, input logic [3:0] a, input logic [2:0] l);
        start      = 1'b1;
        write_en   = w;
        read_en    = r;
        address_in = a;
        burst_len  = l;
        tick();
        start    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {busy, rd_valid, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cs    = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got %b want 000", {busy, rd_valid, done});
        end
        tick();
    endtask

    task automatic test_write_burst();
        logic [2:0] exp;
        cmd(1'b1, 1'b0, 4'd4, 3'd3);
        for (int i = 0; i < 4; i++) begin
            tb_oe  = 1'b1;
            tb_drv = 8'hA0 + 8'(i);
            @(negedge clk);
            exp = {1'b1, 1'b0, (i == 3)};
            checks++;
            if ({busy, rd_valid, done} !== exp) begin
                errors++;
                $display("FAIL write_beat%0d got %b want %b", i, {busy, rd_valid, done}, exp);
            end
            tick();
        end
        tb_oe = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL write_after got %b want 000", {busy, rd_valid, done});
        end
        tick();
    endtask

    task automatic test_read_burst();
        logic [2:0] exp;
        logic [7:0] expd;
        cmd(1'b0, 1'b1, 4'd4, 3'd3);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp = {(c <= 5), (c >= 2 && c <= 5), (c == 5)};
            checks++;
            if ({busy, rd_valid, done} !== exp) begin
                errors++;
                $display("FAIL read_flags_c%0d got %b want %b", c, {busy, rd_valid, done}, exp);
            end
            if (c >= 2 && c <= 5) begin
                expd = 8'hA0 + 8'(c - 2);
                checks++;
                if (data_io !== expd) begin
                    errors++;
                    $display("FAIL read_data_c%0d got %h want %h", c, data_io, expd);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wd [4];
        logic [7:0] got [$];
        int         ndone;
        wd = '{8'h11, 8'h22, 8'h33, 8'h44};
        cmd(1'b1, 1'b0, 4'd14, 3'd3);
        for (int i = 0; i < 4; i++) begin
            tb_oe  = 1'b1;
            tb_drv = wd[i];
            tick();
        end
        tb_oe = 1'b0;
        tick();
        cmd(1'b0, 1'b1, 4'd14, 3'd3);
        ndone = 0;
        for (int c = 0; c < 12 && busy; c++) begin
            @(negedge clk);
            if (rd_valid) got.push_back(data_io);
            if (done) ndone++;
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_timeout busy got %b want 0", busy);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL wrap_count got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== wd[i]) begin
                errors++;
                $display("FAIL wrap_word%0d got %h want %h", i, got[i], wd[i]);
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL wrap_done got %0d want 1", ndone);
        end
        // single-beat read of the wrapped word at address 0
        cmd(1'b0, 1'b1, 4'd0, 3'd0);
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b100) begin
            errors++;
            $display("FAIL single_c1 got %b want 100", {busy, rd_valid, done});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done, data_io} !== {3'b111, 8'h33}) begin
            errors++;
            $display("FAIL single_c2 got %b/%h want 111/33", {busy, rd_valid, done}, data_io);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL single_c3 got %b want 000", {busy, rd_valid, done});
        end
        tick();
    endtask

    task automatic test_cs_pause();
        logic       rv [8];
        logic [7:0] dd [8];
        logic [2:0] exp;
        rv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        dd = '{8'h00, 8'hA0, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        cmd(1'b0, 1'b1, 4'd4, 3'd3);
        for (int c = 1; c <= 8; c++) begin
            cs = !(c == 2 || c == 3);
            @(negedge clk);
            exp = {(c <= 7), rv[c-1], (c == 7)};
            checks++;
            if ({busy, rd_valid, done} !== exp) begin
                errors++;
                $display("FAIL pause_flags_c%0d got %b want %b", c, {busy, rd_valid, done}, exp);
            end
            if (rv[c-1]) begin
                checks++;
                if (data_io !== dd[c-1]) begin
                    errors++;
                    $display("FAIL pause_data_c%0d got %h want %h", c, data_io, dd[c-1]);
                end
            end
            tick();
        end
        cs = 1'b1;
    endtask

    task automatic test_commands();
        // both enables: write wins, single beat completes in the first cycle
        cmd(1'b1, 1'b1, 4'd8, 3'd0);
        tb_oe  = 1'b1;
        tb_drv = 8'h5C;
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b101) begin
            errors++;
            $display("FAIL both_en got %b want 101", {busy, rd_valid, done});
        end
        tick();
        tb_oe = 1'b0;
        cmd(1'b0, 1'b1, 4'd8, 3'd0);
        tick();
        @(negedge clk);
        checks++;
        if ({rd_valid, data_io} !== {1'b1, 8'h5C}) begin
            errors++;
            $display("FAIL both_en_readback got %b/%h want 1/5c", rd_valid, data_io);
        end
        tick();
        // start while busy is ignored
        cmd(1'b1, 1'b0, 4'd9, 3'd1);
        tb_oe      = 1'b1;
        tb_drv     = 8'h66;
        start      = 1'b1;
        read_en    = 1'b1;
        address_in = 4'd0;
        burst_len  = 3'd7;
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b100) begin
            errors++;
            $display("FAIL busy_start_c1 got %b want 100", {busy, rd_valid, done});
        end
        tick();
        start   = 1'b0;
        read_en = 1'b0;
        tb_drv  = 8'h77;
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b101) begin
            errors++;
            $display("FAIL busy_start_c2 got %b want 101", {busy, rd_valid, done});
        end
        tick();
        tb_oe = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL busy_start_c3 got %b want 000", {busy, rd_valid, done});
        end
        tick();
        // start with cs low stays idle
        cs       = 1'b0;
        start    = 1'b1;
        write_en = 1'b1;
        tick();
        start    = 1'b0;
        write_en = 1'b0;
        cs       = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL cs_low_start got %b want 000", {busy, rd_valid, done});
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] got [$];
        cmd(1'b0, 1'b1, 4'd4, 3'd3);
        tick();
        #1;
        checks++;
        if ({busy, rd_valid, data_io} !== {2'b11, 8'hA0}) begin
            errors++;
            $display("FAIL rst_mid_pre got %b/%h want 11/a0", {busy, rd_valid}, data_io);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rd_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_flags got %b want 000", {busy, rd_valid, done});
        end
        tb_oe  = 1'b1;
        tb_drv = 8'h00;
        #1;
        checks++;
        if (data_io !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_bus_released got %h want 00", data_io);
        end
        tb_oe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cmd(1'b0, 1'b1, 4'd4, 3'd3);
        for (int c = 0; c < 12 && busy; c++) begin
            @(negedge clk);
            if (rd_valid) got.push_back(data_io);
            tick();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL rst_reread_count got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL rst_reread_word%0d got %h want %h", i, got[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_cs_pause();
        test_commands();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_memory_inout.md
Name: burst_memory_inout

Overview:
- Parametrised single-port synchronous RAM with a shared bidirectional data bus and a burst engine.
- One command (start + address + length) moves 1..2**BURST_W consecutive words, with the address auto-incrementing and wrapping.
- Read data is registered and driven onto the tri-state bus only while valid.
- Sits between a bus master and local storage; it is the next generation of the team's fixed 16-deep inout memory.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 4, address width. Depth is the localparam DEPTH = 2**ADDR_W.
- BURST_W, 3, width of burst_len. Maximum burst is 2**BURST_W beats.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  1  chip select. Low pauses an active burst and blocks new commands.
- start  input  1  command strobe, sampled in IDLE only.
- write_en  input  1  command type: write burst.
- read_en  input  1  command type: read burst.
- address_in  input  ADDR_W  burst start address, sampled with start.
- burst_len  input  BURST_W  beats minus 1, sampled with start.
- data_io  inout  DATA_W  write data in; registered read data out; hi-Z otherwise.
- busy  output  1  high whenever state is not IDLE.
- rd_valid  output  1  data_io carries valid read data this cycle.
- done  output  1  one-cycle pulse on the final beat of a burst.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release):
  - state = IDLE; addr_ptr = 0; beat_cnt = 0.
  - busy, rd_valid and done = 0; data_io hi-Z immediately.
  - RAM contents are not reset.
- FSM states: IDLE, WR, RD, RD_TAIL.
- IDLE:
  - start && cs latches addr_ptr <= address_in and beat_cnt <= burst_len.
  - write_en -> WR; else read_en -> RD; neither -> stay in IDLE.
  - write_en && read_en together -> write wins.
  - The start cycle is command only: no data is transferred.
- WR, each cycle with cs = 1:
  - mem[addr_ptr] <= data_io; addr_ptr <= addr_ptr + 1 (mod DEPTH); beat_cnt decrements.
  - When beat_cnt == 0 on that beat: done = 1 in the same cycle, next state IDLE.
- RD, each cycle with cs = 1:
  - rdata <= mem[addr_ptr]; rd_valid <= 1 next cycle; addr_ptr increments and wraps; beat_cnt decrements.
  - When beat_cnt == 0 on the issuing beat: next state RD_TAIL.
- RD_TAIL: rd_valid = 1 carrying the last word; done = 1; next state IDLE.
- Read latency:
  - Data for each issued beat appears exactly 1 cycle after issue.
  - First read data appears 2 cycles after the start edge.
- Bus: data_io = rd_valid ? rdata : 'z. The master must not drive during RD or RD_TAIL.
- cs low during WR or RD: no write, no issue, no pointer or counter change. In RD, rd_valid drops the following cycle. Resumes with no skipped or duplicated beat.
- cs low in RD_TAIL: has no effect; the tail completes.
- start while busy: ignored. write_en and read_en are ignored outside IDLE.
- Wrap: addr_ptr goes from DEPTH-1 to 0. The burst length is independent of the address.
- burst_len = 0: single beat. done falls in the WR beat cycle, or in the RD_TAIL cycle for reads.
- Reset mid-burst: burst is aborted. Already-written words remain; no done is issued.

Decomposition:
- Package burst_mem_pkg:
  - FSM state encoding localparams (IDLE, WR, RD, RD_TAIL).
  - Default width constants.
- Sub-module sp_ram_core (DATA_W, ADDR_W): plain synchronous-write, registered-read array with we, re, addr, wdata, rdata.
- The top level holds the FSM, address/beat counters, rd_valid/done and the tri-state driver.

Test Plan (DATA_W=8, ADDR_W=4, BURST_W=3):
- Write burst: addr 4, len 3, data A0,A1,A2,A3 over 4 cycles -> mem[4..7] = A0..A3; done on the 4th beat; busy low the next cycle.
- Read burst: addr 4, len 3 -> rd_valid high at cycles 2..5 after start with A0..A3 on data_io; done with A3; data_io Z before and after.
- Wrap: write addr 14, len 3 with 11,22,33,44 -> mem[14]=11, mem[15]=22, mem[0]=33, mem[1]=44. Readback from 14 returns 11,22,33,44.
- cs pause: read addr 4, len 3, cs low 2 cycles after first issue -> rd_valid gap of 2 cycles; exactly A0..A3 delivered, in order.
- Command edge cases:
  - start with write_en=read_en=1 -> write burst.
  - start during busy -> ignored; busy timing unchanged.
  - start with cs=0 -> stays IDLE.
- Reset mid-read: rst_n low at 2nd beat -> rd_valid, busy and done go 0 and data_io goes Z in the same cycle, asynchronously. A new read after release returns the correct data.
